// File: rtl/coproc_alu_exec_if.sv
// Command/response bundle for the co-processor execution stage.
// master: command source and UART TX side (drives operands, start, tx_busy).
// slave:  execution stage (drives TX byte stream and result/status flags).
interface coproc_alu_exec_if;
  logic        i_start;
  logic [7:0]  i_num_1;
  logic [7:0]  i_num_2;
  logic [7:0]  i_opcode;
  logic        i_tx_busy;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic [15:0] o_result;
  logic        o_result_valid;
  logic        o_err;
  logic        o_busy;
  logic        o_overrun;

  modport master (
    output i_start, i_num_1, i_num_2, i_opcode, i_tx_busy,
    input  o_tx_start, o_tx_data, o_result, o_result_valid, o_err, o_busy, o_overrun
  );

  modport slave (
    input  i_start, i_num_1, i_num_2, i_opcode, i_tx_busy,
    output o_tx_start, o_tx_data, o_result, o_result_valid, o_err, o_busy, o_overrun
  );
endinterface

// File: rtl/coproc_alu_exec.sv
// Execution stage of the co-processor: latches an operand/opcode triple on the
// rising edge of i_start, computes a 16-bit result (MUL/DIV as 8-step loops)
// and streams it to the UART transmitter as high byte then low byte.
// Ports:
//   i_clk  - system clock
//   reset  - asynchronous, active-high reset
//   bus    - slave side of coproc_alu_exec_if (command in, TX bytes and status out)
module coproc_alu_exec (
  input logic              i_clk,
  input logic              reset,
  coproc_alu_exec_if.slave bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StExec    = 3'd1;
  localparam logic [2:0] StIter    = 3'd2;
  localparam logic [2:0] StSendHi  = 3'd3;
  localparam logic [2:0] StGuardHi = 3'd4;
  localparam logic [2:0] StSendLo  = 3'd5;
  localparam logic [2:0] StGuardLo = 3'd6;

  localparam logic [7:0] OpAdd = 8'h00;
  localparam logic [7:0] OpSub = 8'h01;
  localparam logic [7:0] OpMul = 8'h02;
  localparam logic [7:0] OpDiv = 8'h03;
  localparam logic [7:0] OpAnd = 8'h04;
  localparam logic [7:0] OpOr  = 8'h05;
  localparam logic [7:0] OpXor = 8'h06;

  logic [2:0]  state_q, state_d;
  logic        start_q;
  logic [7:0]  a_q, a_d, b_q, b_d, op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] work_q, work_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic        start_edge;
  logic [15:0] mul_addend, iter_next;
  logic [8:0]  div_trial, div_rem;
  logic        div_ge, div_by_zero;

  assign start_edge  = bus.i_start & ~start_q;
  assign div_by_zero = (b_q == 8'h00);

  // One iteration step. MUL: shift-add, work holds the accumulator.
  // DIV: restoring division, work holds {remainder, dividend/quotient}.
  always_comb begin
    mul_addend = b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000;
    div_trial  = work_q[15:7];
    div_ge     = (div_trial >= {1'b0, b_q});
    div_rem    = div_ge ? (div_trial - {1'b0, b_q}) : div_trial;
    if (op_q == OpMul) begin
      iter_next = work_q + mul_addend;
    end else begin
      iter_next = {div_rem[7:0], work_q[6:0], div_ge};
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    busy_d     = busy_q;
    // Edges outside IDLE are dropped but remembered.
    overrun_d  = overrun_q | (start_edge & (state_q != StIdle));

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          a_d     = bus.i_num_1;
          b_d     = bus.i_num_2;
          op_d    = bus.i_opcode;
          busy_d  = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        cnt_d    = 3'd0;
        work_d   = (op_q == OpDiv) ? {8'h00, a_q} : 16'h0000;
        valid_d  = 1'b1;
        err_d    = 1'b0;
        state_d  = StSendHi;
        case (op_q)
          OpAdd: result_d = {8'h00, a_q} + {8'h00, b_q};
          OpSub: result_d = {8'h00, a_q} - {8'h00, b_q};
          OpAnd: result_d = {8'h00, a_q & b_q};
          OpOr:  result_d = {8'h00, a_q | b_q};
          OpXor: result_d = {8'h00, a_q ^ b_q};
          OpMul, OpDiv: begin
            valid_d = 1'b0;
            err_d   = err_q;
            state_d = StIter;
          end
          default: begin
            result_d = 16'h0000;
            err_d    = 1'b1;
          end
        endcase
      end
      StIter: begin
        work_d = iter_next;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Divide-by-zero still runs the full loop; the result is overridden.
          if ((op_q == OpDiv) && div_by_zero) begin
            result_d = 16'hFFFF;
            err_d    = 1'b1;
          end else begin
            result_d = iter_next;
            err_d    = 1'b0;
          end
          valid_d = 1'b1;
          state_d = StSendHi;
        end
      end
      StSendHi: begin
        if (!bus.i_tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = result_q[15:8];
          state_d    = StGuardHi;
        end
      end
      // TX busy may lag our start pulse by a cycle, so it is ignored here.
      StGuardHi: state_d = StSendLo;
      StSendLo: begin
        if (!bus.i_tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = result_q[7:0];
          state_d    = StGuardLo;
        end
      end
      StGuardLo: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= 8'h00;
      cnt_q      <= 3'd0;
      work_q     <= 16'h0000;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      result_q   <= 16'h0000;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= bus.i_start;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.o_tx_start     = tx_start_q;
  assign bus.o_tx_data      = tx_data_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = valid_q;
  assign bus.o_err          = err_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_overrun      = overrun_q;

endmodule

// File: tb/tb_coproc_alu_exec.sv
// Directed bench for coproc_alu_exec: arithmetic/logic vectors, latency,
// TX byte order and backpressure, overrun and asynchronous reset.
module tb_coproc_alu_exec;
  logic clk = 1'b0;
  logic rst = 1'b0;

  int unsigned n_vec   = 0;
  int unsigned n_bad   = 0;
  int unsigned n_valid = 0;
  int unsigned n_viol  = 0;
  logic        busy_prev = 1'b0;
  logic [7:0]  txq[$];

  coproc_alu_exec_if bus ();

  coproc_alu_exec dut (
    .i_clk (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // i_tx_busy as seen by the DUT at each active edge.
  always @(posedge clk) busy_prev <= bus.i_tx_busy;

  always @(negedge clk) begin
    if (bus.o_tx_start) begin
      txq.push_back(bus.o_tx_data);
      if (busy_prev) n_viol++;
    end
    if (bus.o_result_valid) n_valid++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an active edge. lat counts edges after E0 (E0 = 0).
  task automatic start_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int hold, input int poke, output int lat, output logic busy0);
    bus.i_num_1  = a;
    bus.i_num_2  = b;
    bus.i_opcode = op;
    bus.i_start  = 1'b1;
    lat   = -1;
    busy0 = 1'b0;
    while (lat < 40) begin
      tick();
      lat++;
      if (lat == 0) busy0 = bus.o_busy;
      if (lat + 1 == hold) bus.i_start = 1'b0;
      if (poke >= 0 && lat == poke) begin
        bus.i_start  = 1'b1;
        bus.i_num_1  = 8'hAA;
      end
      if (poke >= 0 && lat == poke + 1) bus.i_start = 1'b0;
      if (bus.o_result_valid) break;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      if (txq.size() >= 2 && !bus.o_busy) break;
      tick();
    end
  endtask

  task automatic check_tx(input string tag, input logic [15:0] exp);
    logic [7:0] hi, lo;
    hi = (txq.size() > 0) ? txq[0] : 8'hxx;
    lo = (txq.size() > 1) ? txq[1] : 8'hxx;
    check_eq({tag, " tx count"}, txq.size(), 2);
    check_eq({tag, " tx hi"}, 32'(hi), 32'(exp[15:8]));
    check_eq({tag, " tx lo"}, 32'(lo), 32'(exp[7:0]));
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input int hold, input logic [15:0] exp_res,
                         input logic exp_err, input int exp_lat);
    int   lat;
    logic busy0;
    txq.delete();
    n_valid = 0;
    start_cmd(a, b, op, hold, -1, lat, busy0);
    check_eq({tag, " result"}, 32'(bus.o_result), 32'(exp_res));
    check_eq({tag, " err"}, 32'(bus.o_err), 32'(exp_err));
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " busy after E0"}, 32'(busy0), 1);
    wait_done();
    check_tx(tag, exp_res);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " tx_start"}, 32'(bus.o_tx_start), 0);
    check_eq({tag, " tx_data"}, 32'(bus.o_tx_data), 0);
    check_eq({tag, " result"}, 32'(bus.o_result), 0);
    check_eq({tag, " valid"}, 32'(bus.o_result_valid), 0);
    check_eq({tag, " err"}, 32'(bus.o_err), 0);
    check_eq({tag, " busy"}, 32'(bus.o_busy), 0);
    check_eq({tag, " overrun"}, 32'(bus.o_overrun), 0);
  endtask

  initial begin
    int   lat;
    logic b0;
    bus.i_start   = 1'b0;
    bus.i_num_1   = 8'h00;
    bus.i_num_2   = 8'h00;
    bus.i_opcode  = 8'h00;
    bus.i_tx_busy = 1'b0;

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check_reset_outputs("por");

    // ADD with start held 2 cycles: one command only.
    run_cmd("add", 8'hFF, 8'h01, 8'h00, 2, 16'h0100, 1'b0, 1);
    repeat (6) tick();
    check_eq("add single command", n_valid, 1);
    check_eq("add no overrun", 32'(bus.o_overrun), 0);
    check_eq("add idle", 32'(bus.o_busy), 0);

    run_cmd("sub", 8'h03, 8'h05, 8'h01, 1, 16'hFFFE, 1'b0, 1);
    run_cmd("mul 0f*11", 8'h0F, 8'h11, 8'h02, 1, 16'h00FF, 1'b0, 9);
    run_cmd("mul ff*ff", 8'hFF, 8'hFF, 8'h02, 1, 16'hFE01, 1'b0, 9);
    run_cmd("div 200/7", 8'd200, 8'd7, 8'h03, 1, 16'h041C, 1'b0, 9);
    run_cmd("div by 0", 8'h12, 8'h00, 8'h03, 1, 16'hFFFF, 1'b1, 9);
    run_cmd("bad op", 8'h12, 8'h34, 8'h09, 1, 16'h0000, 1'b1, 1);
    run_cmd("and", 8'hC3, 8'h5A, 8'h04, 1, 16'h0042, 1'b0, 1);
    run_cmd("or", 8'hC3, 8'h5A, 8'h05, 1, 16'h00DB, 1'b0, 1);
    run_cmd("xor", 8'hC3, 8'h5A, 8'h06, 1, 16'h0099, 1'b0, 1);

    // TX backpressure on both bytes.
    txq.delete();
    n_viol = 0;
    bus.i_tx_busy = 1'b1;
    start_cmd(8'h12, 8'h34, 8'h00, 1, -1, lat, b0);
    check_eq("bp result", 32'(bus.o_result), 32'h0046);
    repeat (20) tick();
    check_eq("bp held while busy", txq.size(), 0);
    bus.i_tx_busy = 1'b0;
    for (int i = 0; i < 10 && !bus.o_tx_start; i++) tick();
    bus.i_tx_busy = 1'b1;
    repeat (10) tick();
    check_eq("bp low byte held", txq.size(), 1);
    bus.i_tx_busy = 1'b0;
    wait_done();
    check_tx("bp", 16'h0046);
    check_eq("bp no start while busy", n_viol, 0);

    // Second start edge during a MUL.
    txq.delete();
    n_valid = 0;
    start_cmd(8'h0F, 8'h11, 8'h02, 1, 3, lat, b0);
    check_eq("ovr result", 32'(bus.o_result), 32'h00FF);
    check_eq("ovr latency", lat, 9);
    check_eq("ovr flag", 32'(bus.o_overrun), 1);
    wait_done();
    check_tx("ovr", 16'h00FF);
    repeat (10) tick();
    check_eq("ovr tx total", txq.size(), 2);
    check_eq("ovr one result", n_valid, 1);
    check_eq("ovr sticky", 32'(bus.o_overrun), 1);

    // Asynchronous reset in the middle of ITER, between clock edges.
    txq.delete();
    n_valid = 0;
    bus.i_num_1  = 8'hFF;
    bus.i_num_2  = 8'hFF;
    bus.i_opcode = 8'h02;
    bus.i_start  = 1'b1;
    repeat (5) tick();
    bus.i_start = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_reset_outputs("mid rst");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    repeat (20) tick();
    check_eq("mid rst no tx", txq.size(), 0);
    check_eq("mid rst no result", n_valid, 0);
    run_cmd("post rst div", 8'd200, 8'd7, 8'h03, 1, 16'h041C, 1'b0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
